// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decode-stage immediate generator with a registered
// valid/ready output stage backed by a one-entry skid register.
// Optional feature macro: IMMGEN_ILLEGAL_EN (adds out_err storage for unknown opcodes).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// in_ready comes from a register (it is !skid_valid) and never depends
// combinationally on out_ready. out_* hold steady while out_valid && !out_ready.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_X = 3'd7;

    logic            w_sign;
    logic [2:0]      w_fmt;
    logic [XLEN-1:0] w_imm;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [2:0]       r_main_fmt;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_in_ready;

    logic w_accept;
    logic w_main_free;
    logic w_main_load_skid;
    logic w_main_load_in;
    logic w_skid_load;
    logic w_main_valid_nxt;
    logic w_skid_valid_nxt;

    assign w_sign = in_instr[31];

    // Classify the opcode and rebuild the sign-extended immediate.
    always_comb begin
        w_fmt = FMT_X;
        w_imm = '0;
        case (in_instr[6:0])
            7'b0110011: w_fmt = FMT_R;
            7'b0111011: if (XLEN == 64) w_fmt = FMT_R;
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                w_fmt = FMT_I;
                w_imm = {{(XLEN-11){w_sign}}, in_instr[30:20]};
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    w_fmt = FMT_I;
                    w_imm = {{(XLEN-11){w_sign}}, in_instr[30:20]};
                end
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                w_imm = {{(XLEN-11){w_sign}}, in_instr[30:25], in_instr[11:7]};
            end
            7'b1100011: begin
                w_fmt = FMT_B;
                w_imm = {{(XLEN-12){w_sign}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt = FMT_U;
                w_imm = {{(XLEN-31){w_sign}}, in_instr[30:12], 12'b0};
            end
            7'b1101111: begin
                w_fmt = FMT_J;
                w_imm = {{(XLEN-20){w_sign}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                w_fmt = FMT_X;
                w_imm = '0;
            end
        endcase
    end

    // Steer entries between input, main and skid; the skid only fills while main is held.
    always_comb begin
        w_accept         = in_valid && r_in_ready;
        w_main_free      = !r_main_valid || out_ready;
        w_main_load_skid = w_main_free && r_skid_valid;
        w_main_load_in   = w_main_free && !r_skid_valid && w_accept;
        w_skid_load      = !w_main_free && w_accept;
        w_main_valid_nxt = w_main_free ? (r_skid_valid || w_accept) : 1'b1;
        w_skid_valid_nxt = w_main_free ? 1'b0 : (r_skid_valid || w_accept);
    end

`ifdef IMMGEN_ILLEGAL_EN
    logic w_err;
    logic r_main_err;
    logic r_skid_err;
    assign w_err   = (w_fmt == FMT_X);
    assign out_err = r_main_err;
`else
    assign out_err = 1'b0;
`endif

    // Pipeline registers: reset and flush discard everything, otherwise move entries in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_fmt   <= '0;
            r_main_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= '0;
            r_skid_tag   <= '0;
            r_in_ready   <= 1'b0;
`ifdef IMMGEN_ILLEGAL_EN
            r_main_err   <= 1'b0;
            r_skid_err   <= 1'b0;
`endif
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            if (w_main_load_skid) begin
                r_main_imm <= r_skid_imm;
                r_main_fmt <= r_skid_fmt;
                r_main_tag <= r_skid_tag;
`ifdef IMMGEN_ILLEGAL_EN
                r_main_err <= r_skid_err;
`endif
            end else if (w_main_load_in) begin
                r_main_imm <= w_imm;
                r_main_fmt <= w_fmt;
                r_main_tag <= in_tag;
`ifdef IMMGEN_ILLEGAL_EN
                r_main_err <= w_err;
`endif
            end
            if (w_skid_load) begin
                r_skid_imm <= w_imm;
                r_skid_fmt <= w_fmt;
                r_skid_tag <= in_tag;
`ifdef IMMGEN_ILLEGAL_EN
                r_skid_err <= w_err;
`endif
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_imm   = r_main_imm;
    assign out_fmt   = r_main_fmt;
    assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an XLEN=32 and an XLEN=64 instance share one
// stimulus stream; a scoreboard queue holds expected entries and a negedge
// monitor pops and compares on every output transfer.
module tb_imm_gen_stage;

    typedef struct {
        logic [31:0] tag;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt32;
        logic [2:0]  fmt64;
        logic        err32;
        logic        err64;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, in_ready64;
    logic        out_valid32, out_valid64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt32, out_fmt64;
    logic [31:0] out_tag32, out_tag64;
    logic        out_err32, out_err64;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];
    logic last_acc;
    logic [6:0] op_tbl [0:15];

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_tag(out_tag32), .out_err(out_err32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_tag(out_tag64), .out_err(out_err64)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference format table, one entry per opcode
    function automatic logic [2:0] ref_fmt(input logic [6:0] op, input bit is64);
        case (op)
            7'h33: return 3'd0;
            7'h3B: return is64 ? 3'd0 : 3'd7;
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return 3'd1;
            7'h1B: return is64 ? 3'd1 : 3'd7;
            7'h23: return 3'd2;
            7'h63: return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F: return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    // Immediate value as a signed integer, built from weighted instruction fields
    function automatic longint ref_val(input logic [31:0] instr, input logic [2:0] fmt);
        longint w;
        w = longint'($signed(instr));
        case (fmt)
            3'd1: return w >>> 20;
            3'd2: return (w >>> 25) * 32 + ((w >>> 7) & 31);
            3'd3: return (w >>> 31) * 4096 + ((w >>> 7) & 1) * 2048
                         + ((w >>> 25) & 63) * 32 + ((w >>> 8) & 15) * 2;
            3'd4: return (w >>> 12) * 4096;
            3'd5: return (w >>> 31) * 1048576 + ((w >>> 12) & 255) * 4096
                         + ((w >>> 20) & 1) * 2048 + ((w >>> 21) & 1023) * 2;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] tag);
        exp_t e;
        longint v32, v64;
        e.tag   = tag;
        e.fmt32 = ref_fmt(instr[6:0], 1'b0);
        e.fmt64 = ref_fmt(instr[6:0], 1'b1);
        v32     = ref_val(instr, e.fmt32);
        v64     = ref_val(instr, e.fmt64);
        e.imm32 = v32[31:0];
        e.imm64 = v64;
`ifdef IMMGEN_ILLEGAL_EN
        e.err32 = (e.fmt32 == 3'd7);
        e.err64 = (e.fmt64 == 3'd7);
`else
        e.err32 = 1'b0;
        e.err64 = 1'b0;
`endif
        return e;
    endfunction

    // driver: one clock cycle of stimulus, entered and left at posedge+1
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                         input logic fl, input logic rdy, input bit use_ov, input exp_t ov);
        logic acc;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        flush     = fl;
        out_ready = rdy;
        acc = v && in_ready32 && !fl && !rst;
        @(posedge clk);
        if (fl || rst) exp_q.delete();
        if (acc) exp_q.push_back(use_ov ? ov : model(ins, tg));
        last_acc = acc;
        #1;
    endtask

    task automatic send(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic fl, input logic rdy);
        exp_t none;
        none = '{default: '0};
        cycle(v, ins, tg, fl, rdy, 1'b0, none);
    endtask

    task automatic dir(input logic [31:0] ins, input logic [31:0] tg, input logic [31:0] i32,
                       input logic [63:0] i64, input logic [2:0] f32, input logic [2:0] f64,
                       input logic e);
        exp_t ov;
        ov.tag = tg; ov.imm32 = i32; ov.imm64 = i64; ov.fmt32 = f32; ov.fmt64 = f64;
        ov.err32 = e; ov.err64 = e;
        cycle(1'b1, ins, tg, 1'b0, 1'b1, 1'b1, ov);
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_valid"}, {63'd0, out_valid32}, 64'd0);
        chk({nm, "_imm32"}, {32'd0, out_imm32}, 64'd0);
        chk({nm, "_imm64"}, out_imm64, 64'd0);
        chk({nm, "_fmt"}, {61'd0, out_fmt32}, 64'd0);
        chk({nm, "_tag"}, {32'd0, out_tag32}, 64'd0);
        chk({nm, "_err"}, {62'd0, out_err32, out_err64}, 64'd0);
    endtask

    // scoreboard monitor: compare on every output transfer, check stability while held
    logic        hold_prev = 1'b0;
    logic [31:0] h_imm32, h_tag;
    logic [63:0] h_imm64;
    logic [2:0]  h_fmt;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("held_valid", {63'd0, out_valid32}, 64'd1);
                chk("held_imm32", {32'd0, out_imm32}, {32'd0, h_imm32});
                chk("held_imm64", out_imm64, h_imm64);
                chk("held_fmt", {61'd0, out_fmt32}, {61'd0, h_fmt});
                chk("held_tag", {32'd0, out_tag32}, {32'd0, h_tag});
            end
            chk("valid_pair", {63'd0, out_valid64}, {63'd0, out_valid32});
            if (out_valid32 && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_tag", {32'd0, out_tag32}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tag32", {32'd0, out_tag32}, {32'd0, e.tag});
                    chk("tag64", {32'd0, out_tag64}, {32'd0, e.tag});
                    chk("imm32", {32'd0, out_imm32}, {32'd0, e.imm32});
                    chk("imm64", out_imm64, e.imm64);
                    chk("fmt32", {61'd0, out_fmt32}, {61'd0, e.fmt32});
                    chk("fmt64", {61'd0, out_fmt64}, {61'd0, e.fmt64});
                    chk("err32", {63'd0, out_err32}, {63'd0, e.err32});
                    chk("err64", {63'd0, out_err64}, {63'd0, e.err64});
                end
            end
            hold_prev = out_valid32 && !out_ready && !flush;
            h_imm32 = out_imm32; h_imm64 = out_imm64; h_fmt = out_fmt32; h_tag = out_tag32;
        end
    end

    initial begin
        logic        ill;
        logic [31:0] ins;
        logic [31:0] tg;
        logic        v;
        int          n;
        op_tbl = '{7'h33, 7'h3B, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h1B,
                   7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00, 7'h5B};
`ifdef IMMGEN_ILLEGAL_EN
        ill = 1'b1;
`else
        ill = 1'b0;
`endif
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093;
        in_tag = 32'hDEAD; out_ready = 1'b1; last_acc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {62'd0, in_ready32, in_ready64}, 64'd0);
        chk_idle_zero("rst");
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {62'd0, in_ready32, in_ready64}, 64'd3);

        // directed formats
        dir(32'hFFF00093, 32'h101, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 3'd1, 1'b0);
        chk("latency_valid", {63'd0, out_valid32}, 64'd1);
        dir(32'hFE000EE3, 32'h102, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 3'd3, 1'b0);
        dir(32'h001000EF, 32'h103, 32'h0000_0800, 64'h0000_0000_0000_0800, 3'd5, 3'd5, 1'b0);
        dir(32'h800002B7, 32'h104, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 3'd4, 1'b0);
        dir(32'h0000007F, 32'h105, 32'h0, 64'h0, 3'd7, 3'd7, ill);
        dir(32'h0000003B, 32'h106, 32'h0, 64'h0, 3'd7, 3'd0, 1'b0);
        chk("err_rv64_only", {63'd0, out_err32}, {63'd0, ill});
        send(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        send(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // backpressure: tags 1,2,3 offered with out_ready low
        send(1'b1, 32'h00A00093, 32'd1, 1'b0, 1'b0);
        send(1'b1, 32'hFEB52E23, 32'd2, 1'b0, 1'b0);
        chk("bp_in_ready_full", {63'd0, in_ready32}, 64'd0);
        chk("bp_tag_held", {32'd0, out_tag32}, 64'd1);
        send(1'b1, 32'h123452B7, 32'd3, 1'b0, 1'b0);
        chk("bp_tag3_refused", {63'd0, last_acc}, 64'd0);
        send(1'b1, 32'h123452B7, 32'd3, 1'b0, 1'b1);
        chk("bp_skid_moved_tag", {32'd0, out_tag32}, 64'd2);
        send(1'b1, 32'h123452B7, 32'd3, 1'b0, 1'b1);
        chk("bp_tag3_taken", {63'd0, last_acc}, 64'd1);
        chk("bp_tag3_out", {32'd0, out_tag32}, 64'd3);
        send(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // flush with main and skid full and input offered
        send(1'b1, 32'h00100093, 32'h10, 1'b0, 1'b0);
        send(1'b1, 32'h00200093, 32'h11, 1'b0, 1'b0);
        send(1'b1, 32'h00300093, 32'h12, 1'b1, 1'b0);
        chk("flush_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready32}, 64'd1);
        // flush while the head drains: the drained entry still counts
        send(1'b1, 32'h00400093, 32'h20, 1'b0, 1'b0);
        send(1'b1, 32'h00500093, 32'h21, 1'b1, 1'b1);
        chk("flush_drain_valid", {63'd0, out_valid32}, 64'd0);
        send(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // reset mid-stream
        send(1'b1, 32'hFFF00093, 32'h30, 1'b0, 1'b0);
        send(1'b1, 32'h800002B7, 32'h31, 1'b0, 1'b0);
        rst = 1'b1;
        send(1'b1, 32'h001000EF, 32'h32, 1'b0, 1'b0);
        chk_idle_zero("midrst");
        chk("midrst_in_ready", {63'd0, in_ready32}, 64'd0);
        rst = 1'b0;
        send(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("midrst_in_ready_after", {63'd0, in_ready32}, 64'd1);

        // randomized traffic; upstream holds an offer until it is taken
        v = 1'b0; ins = 32'h0; tg = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            logic fl;
            if (!v || last_acc) begin
                v   = ($urandom_range(0, 3) != 0);
                ins = {$urandom_range(0, 32'h1FF_FFFF), op_tbl[$urandom_range(0, 15)]};
                tg  = tg + 32'd1;
            end
            fl = ($urandom_range(0, 59) == 0);
            send(v, ins, tg, fl, ($urandom_range(0, 3) != 0));
            if (fl) v = 1'b0;
        end

        // drain with a bounded budget
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            send(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        send(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", {63'd0, out_valid32}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

- Decode-stage immediate generator for the RV32/RV64 core.
- Takes a raw 32-bit instruction and classifies its format (R/I/S/B/U/J) from the opcode.
- Reassembles and sign-extends the immediate to XLEN bits.
- Delivers the result through a registered valid/ready stage with a 2-entry skid buffer. Downstream stalls never drop or duplicate an instruction.

## Interface
Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 32, width of the side-band tag (typically the PC) carried alongside each instruction.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  side-band tag; passed through unmodified.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=unknown.
- out_tag  out  TAG_W  tag of the output entry.
- out_err  out  1  unknown-opcode flag (see Configuration).

## Operation
Format decode uses opcode in_instr[6:0]:
- R: 0110011; 0111011 (XLEN=64 only). Immediate is 0.
- I: 0000011, 0010011, 1100111, 0001111, 1110011; 0011011 (XLEN=64 only). Immediate is sext(instr[31:20]).
- S: 0100011. Immediate is sext({instr[31:25], instr[11:7]}).
- B: 1100011. Immediate is sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- U: 0110111, 0010111. Immediate is sext({instr[31:12], 12'b0}). At XLEN=64, bit 31 is replicated into the upper 32 bits.
- J: 1101111. Immediate is sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Any other opcode, including the 64-bit-only opcodes when XLEN=32: fmt=7, imm=0.
- Sign bit is always instr[31]. Every bit of out_imm is a defined value; there are no inferred latches.

Buffering:
- The main register drives out_*; a skid register sits behind it.
- Accept when main is empty, or main is draining this cycle: the new entry goes to main.
- Accept while main is held (out_valid && !out_ready): the new entry goes to skid.
- When main drains and skid is full, skid moves to main.
- Order is strictly FIFO.
- in_ready = !skid_valid, driven from a register. Not combinationally dependent on out_ready.

## Timing
- Latency: an instruction accepted at edge N appears on out_* after edge N; visible in cycle N+1.
- Throughput: 1 instruction/cycle while out_ready=1.
- Reset (rst=1 at an edge):
  - out_valid=0, skid empty, out_imm=0, out_fmt=0, out_tag=0, out_err=0.
  - in_ready=0 while rst=1; in_ready=1 in the first cycle after rst deasserts.
  - Transfers offered during reset are ignored.
- Reset mid-operation: all held entries are lost; same state as power-on reset.
- flush=1 at an edge:
  - Main and skid are cleared, and any input offered in that cycle is dropped.
  - Next cycle: out_valid=0, in_ready=1.
- flush together with out_ready=1: the downstream transfer in that cycle still counts as completed.
- Full condition (main and skid both valid): in_ready=0; in_instr/in_tag must be held by upstream.
- Simultaneous accept and drain with skid full: skid moves to main and input goes to skid. This cannot occur, because in_ready=0 when skid is full.
- Held output: out_* must remain stable while out_valid && !out_ready.

## Configuration
Macro IMMGEN_ILLEGAL_EN.
- Defined: out_err=1 with each entry whose fmt=7, registered with that entry in main/skid.
- Not defined: out_err is tied to 0 and no err storage is built. The fmt=7 / imm=0 behaviour is unchanged.

## Test plan
- I-type: addi x1,x0,-1 (in_instr=0xFFF00093), XLEN=32, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
- B-type: beq x0,x0,-4 (0xFE000EE3) -> out_imm=0xFFFFFFFC, out_fmt=3; then jal x1,+2048 (0x001000EF) -> out_imm=0x00000800, out_fmt=5.
- U-type at XLEN=64: lui x5,0x80000 (0x800002B7) -> out_imm=0xFFFFFFFF80000000, out_fmt=4.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while tags 1,2,3 are offered back to back.
  - During the stall: out_tag=1 held stable; in_ready=0 after tag 2 is accepted; tag 3 held by upstream.
  - After out_ready=1: tags appear as 1,2,3 on consecutive cycles, with no drop or duplicate.
- Flush with main and skid full plus in_valid=1 -> next cycle out_valid=0, in_ready=1; none of the three entries ever appears on the output.
- Unknown opcode 0x0000007F -> out_fmt=7, out_imm=0; out_err=1 with IMMGEN_ILLEGAL_EN defined, out_err=0 without. Reset asserted mid-stream -> out_valid=0 and all outputs 0 the following cycle.
